// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  // Ceiling log2, never below 1 so that single-entry fields stay legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is taken.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req_i,
  input  logic [clog2(N)-1:0]   ptr_i,
  output logic                  any_o,
  output logic [clog2(N)-1:0]   idx_o
);

  localparam int IW = clog2(N);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int j;
    j     = 0;
    any_o = |req_i;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) idx_o = IW'(j);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter sharing one FIFO write port among N streams.
// Latency: 1 cycle to arbitrate; granted beats reach the FIFO combinationally (0 cycles).
// Backpressure: fifo_full stalls the granted stream in BURST; FLUSH ignores it and discards.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int MAX_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic [W-1:0]         fifo_wr_data,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  output logic [clog2(N)-1:0]  grant_id,
  output logic                 busy,
  output logic                 err_overlen,
  output logic [clog2(N)-1:0]  err_src
);

  localparam int IW = clog2(N);
  localparam int CW = clog2(MAX_LEN) + 1;

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           err_q, err_d;
  logic [IW-1:0]  err_src_q, err_src_d;

  logic           pick_any;
  logic [IW-1:0]  pick_idx;
  logic [IW-1:0]  rr_next;
  logic [CW-1:0]  cnt_inc;
  logic           g_valid;
  logic           g_last;

  rr_pick #(.N(N)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign g_valid      = req_valid[grant_q];
  assign g_last       = req_last[grant_q];
  assign rr_next      = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
  assign cnt_inc      = beat_cnt_q + CW'(1);
  assign fifo_wr_data = req_data[int'(grant_q) * W +: W];

  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign err_overlen = err_q;
  assign err_src     = err_src_q;

  // Next-state and handshake decode; reset forces both strobes low.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    err_src_d  = err_src_q;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        req_ready[grant_q] = ~fifo_full;
        fifo_wr_en         = g_valid & ~fifo_full;
        if (g_valid && !fifo_full) begin
          beat_cnt_d = cnt_inc;
          if (g_last) begin
            // A last beat landing exactly on MAX_LEN is still a legal frame.
            state_d  = IDLE;
            rr_ptr_d = rr_next;
          end else if (cnt_inc == CW'(MAX_LEN)) begin
            state_d   = FLUSH;
            err_d     = 1'b1;
            err_src_d = grant_q;
          end
        end
      end
      FLUSH: begin
        req_ready[grant_q] = 1'b1;
        if (g_valid && g_last) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      req_ready  = '0;
      fifo_wr_en = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      err_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      err_src_q  <= err_src_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with per-requester beat sources and a FIFO write log.
// Latency: inputs change 1 time unit after posedge; outputs are snapshotted at negedge.
// Backpressure: fifo_full is driven directly by the stimulus sequence.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int MAX_LEN = 256;
  localparam int DEPTH = 300;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   fifo_wr_data;
  logic           fifo_wr_en;
  logic           fifo_full;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_overlen;
  logic [1:0]     err_src;

  fifo_wr_arbiter #(.N(N), .W(W), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full),
    .grant_id     (grant_id),
    .busy         (busy),
    .err_overlen  (err_overlen),
    .err_src      (err_src)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Beat sources, one per requester.
  logic [W-1:0] sbuf  [N][DEPTH];
  logic         slast [N][DEPTH];
  int           shead [N];
  int           slen  [N];

  // Negedge snapshot of the DUT outputs.
  logic         s_wr_en, s_busy, s_err;
  logic [W-1:0] s_dat;
  logic [N-1:0] s_rdy;
  logic [1:0]   s_grant, s_src;
  logic [W-1:0] wq [$];
  int           err_cnt;
  int           bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (shead[i] < slen[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*W +: W]  = sbuf[i][shead[i]];
        req_last[i]         = slast[i][shead[i]];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*W +: W]  = '0;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      shead[i] = 0;
      slen[i]  = 0;
    end
    drive();
  endtask

  task automatic load(input int id, input logic [W-1:0] base, input int len);
    for (int k = 0; k < len; k++) begin
      sbuf[id][slen[id]]  = base + W'(k);
      slast[id][slen[id]] = (k == len - 1);
      slen[id]++;
    end
    drive();
  endtask

  // One clock: snapshot at negedge, then advance sources past accepted beats.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    s_wr_en = fifo_wr_en;
    s_dat   = fifo_wr_data;
    s_rdy   = req_ready;
    s_grant = grant_id;
    s_busy  = busy;
    s_err   = err_overlen;
    s_src   = err_src;
    acc     = req_valid & req_ready;
    if (fifo_wr_en) wq.push_back(fifo_wr_data);
    if (err_overlen) err_cnt++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) shead[i]++;
    end
    drive();
  endtask

  initial begin
    logic [W-1:0] bases [4];
    logic [1:0]   ids   [4];
    bases = '{32'h10, 32'h20, 32'h30, 32'h13};
    ids   = '{2'd0, 2'd1, 2'd3, 2'd0};

    rst_n     = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    err_cnt   = 0;
    clear_src();

    // Reset state.
    step();
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_grant", 32'(s_grant), 32'd0);
    check("rst_err", 32'(s_err), 32'd0);
    check("rst_err_src", 32'(s_src), 32'd0);
    check("rst_wr_en", 32'(s_wr_en), 32'd0);
    rst_n = 1'b1;
    step();

    // Single frame from requester 2.
    load(2, 32'hA0, 5);
    step();
    check("sf_arb_wr_en", 32'(s_wr_en), 32'd0);
    check("sf_arb_rdy", 32'(s_rdy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("sf_grant", 32'(s_grant), 32'd2);
      check("sf_wr_en", 32'(s_wr_en), 32'd1);
      check("sf_data", s_dat, 32'hA0 + 32'(k));
    end
    step();
    check("sf_busy_end", 32'(s_busy), 32'd0);

    // Return rr_ptr to 0, then three competing frames plus a re-request from 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wq.delete();
    load(0, 32'h10, 3);
    load(0, 32'h13, 3);
    load(1, 32'h20, 3);
    load(3, 32'h30, 3);
    for (int f = 0; f < 4; f++) begin
      step();
      check("rr_gap", 32'(s_wr_en), 32'd0);
      for (int b = 0; b < 3; b++) begin
        step();
        check("rr_grant", 32'(s_grant), 32'(ids[f]));
        check("rr_rdy", 32'(s_rdy), 32'(4'b0001 << ids[f]));
        check("rr_data", s_dat, bases[f] + 32'(b));
      end
    end
    step();
    check("rr_busy_end", 32'(s_busy), 32'd0);
    check("rr_writes", 32'(wq.size()), 32'd12);

    // Backpressure: full for 4 cycles after two beats of an 8-beat frame.
    wq.delete();
    load(1, 32'h40, 8);
    step();
    step();
    step();
    fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_rdy", 32'(s_rdy), 32'd0);
      check("bp_wr_en", 32'(s_wr_en), 32'd0);
      check("bp_busy", 32'(s_busy), 32'd1);
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("bp_resume", s_dat, 32'h42 + 32'(k));
    end
    step();
    check("bp_busy_end", 32'(s_busy), 32'd0);
    check("bp_count", 32'(wq.size()), 32'd8);
    bad = 0;
    for (int k = 0; k < wq.size(); k++) if (wq[k] !== 32'h40 + 32'(k)) bad++;
    check("bp_order", 32'(bad), 32'd0);

    // Over-length: 260 beats from requester 1.
    wq.delete();
    err_cnt = 0;
    load(1, 32'h1000, 260);
    step();
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (s_wr_en !== 1'b1) bad++;
    end
    check("ovl_stream", 32'(bad), 32'd0);
    step();
    check("ovl_err", 32'(s_err), 32'd1);
    check("ovl_err_src", 32'(s_src), 32'd1);
    check("ovl_flush_wr_en", 32'(s_wr_en), 32'd0);
    check("ovl_flush_rdy", 32'(s_rdy), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      step();
      check("ovl_err_pulse", 32'(s_err), 32'd0);
      check("ovl_flush_busy", 32'(s_busy), 32'd1);
    end
    step();
    check("ovl_idle", 32'(s_busy), 32'd0);
    check("ovl_writes", 32'(wq.size()), 32'd256);
    check("ovl_err_cnt", 32'(err_cnt), 32'd1);
    bad = 0;
    for (int k = 0; k < wq.size(); k++) if (wq[k] !== 32'h1000 + 32'(k)) bad++;
    check("ovl_data", 32'(bad), 32'd0);

    // Exact length: last on beat 256 is legal.
    wq.delete();
    err_cnt = 0;
    load(1, 32'h2000, 256);
    for (int k = 0; k < 257; k++) step();
    step();
    check("exact_idle", 32'(s_busy), 32'd0);
    check("exact_writes", 32'(wq.size()), 32'd256);
    check("exact_no_err", 32'(err_cnt), 32'd0);
    check("exact_last_data", wq[255], 32'h20FF);

    // Reset during beat 3 of a 6-beat frame from requester 3.
    load(3, 32'h50, 6);
    step();
    step();
    check("rm_beat1", s_dat, 32'h50);
    step();
    check("rm_beat2", s_dat, 32'h51);
    rst_n = 1'b0;
    step();
    check("rm_wr_en", 32'(s_wr_en), 32'd0);
    check("rm_rdy", 32'(s_rdy), 32'd0);
    rst_n = 1'b1;
    clear_src();
    load(0, 32'h60, 1);
    load(2, 32'h70, 1);
    step();
    check("rm_idle", 32'(s_busy), 32'd0);
    step();
    check("rm_first_grant", 32'(s_grant), 32'd0);
    check("rm_first_data", s_dat, 32'h60);
    step();
    check("rm_gap", 32'(s_wr_en), 32'd0);
    step();
    check("rm_second_grant", 32'(s_grant), 32'd2);
    check("rm_second_data", s_dat, 32'h70);
    step();
    check("rm_busy_end", 32'(s_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, frame-granular arbiter that shares one async FIFO write port (async_fifo_fwft write side) among N requester streams in the FIFO write-clock domain.
- Grants a whole frame (valid/last burst) to one requester, forwards its beats straight into the FIFO, and applies FIFO-full backpressure.
- Frames longer than MAX_LEN beats are truncated; the rest of the over-length frame is flushed and an error is flagged.

Parameters:
- N, 4, number of requesters (2..16).
- W, 32, data width; equals the FIFO C_WIDTH.
- MAX_LEN, 256, maximum beats per frame; equals the FIFO C_DEPTH.

Ports:
- clk  in  1  write-side clock; also the FIFO WR_CLK.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  N  beat valid, one bit per requester.
- req_data  in  N*W  beat data; requester i occupies bits [i*W +: W].
- req_last  in  N  last beat of frame, per requester.
- req_ready  out  N  beat accepted when req_valid[i] & req_ready[i].
- fifo_wr_data  out  W  to FIFO WR_DATA.
- fifo_wr_en  out  1  to FIFO WR_EN.
- fifo_full  in  1  from FIFO WR_FULL.
- grant_id  out  clog2(N)  current/last granted requester.
- busy  out  1  high in BURST or FLUSH.
- err_overlen  out  1  one-cycle pulse on truncation.
- err_src  out  clog2(N)  requester that caused the last err_overlen.

Behaviour:
- States: IDLE, BURST, FLUSH. Registers: state, grant_id, rr_ptr, beat_cnt (clog2(MAX_LEN)+1 bits), err_overlen, err_src.
- IDLE:
  - If any req_valid, select the first set bit searching from rr_ptr upward with wrap-around.
  - Register that index into grant_id, clear beat_cnt, and go to BURST on the next edge.
  - req_ready = 0 and fifo_wr_en = 0 in IDLE. Arbitration costs exactly 1 cycle.
- BURST, with g = grant_id:
  - req_ready[g] = ~fifo_full; every other ready bit is 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - fifo_wr_data = req_data[g], combinational, so latency is 0 cycles.
  - An accepted beat increments beat_cnt.
- Accepted beat with req_last[g]:
  - Go to IDLE and set rr_ptr = g+1 (mod N).
  - Frames are separated by at least one IDLE cycle.
- Accepted beat number MAX_LEN without last:
  - That beat is written. Go to FLUSH.
  - Pulse err_overlen for 1 cycle, starting the cycle after that beat; set err_src = g.
- Last and MAX_LEN on the same beat: the frame is legal. Go to IDLE; no error.
- FLUSH:
  - req_ready[g] = 1, fifo_wr_en = 0, and beats are discarded regardless of fifo_full.
  - The accepted beat with last goes to IDLE with the rr_ptr update.
- fifo_full high: stalls BURST only. No beat is lost and no counter advances.
- req_valid[g] dropping mid-frame: this is a bubble, not an end of frame. The grant is held.
- Only the granted requester's req_valid is observed during BURST/FLUSH. Other requests wait.
- Reset (rst_n low at a posedge):
  - state = IDLE, rr_ptr = 0, grant_id = 0, beat_cnt = 0, err_overlen = 0, err_src = 0.
  - Additionally, req_ready and fifo_wr_en are forced to 0 combinationally while rst_n = 0.
  - A frame interrupted by reset is abandoned mid-stream; there is no recovery.
- busy = (state != IDLE).

Decomposition:
- Shared package fifo_arb_pkg: state encoding (IDLE=2'd0, BURST=2'd1, FLUSH=2'd2) and a clog2 function.
- Sub-module rr_pick: combinational round-robin priority picker; inputs req[N] and ptr; outputs any and idx.

Test Plan:
- Single frame: N=4; req 2 sends 5 beats 0xA0..0xA4 with last on 0xA4.
  - Expect grant_id=2 one cycle after valid.
  - Expect 5 consecutive fifo_wr_en cycles carrying 0xA0..0xA4, then busy=0.
- Round robin: reqs 0, 1 and 3 each hold 3-beat frames simultaneously.
  - Expect FIFO order 0,1,3, then 0 again if re-requested.
  - Expect 1 IDLE cycle between frames.
- Backpressure: fifo_full held high for 4 cycles mid-frame of 8 beats.
  - Expect req_ready=0 and fifo_wr_en=0 during those cycles.
  - Expect all 8 beats written, in order, without duplicates.
- Over-length: 260-beat frame from req 1, last on beat 260, MAX_LEN=256.
  - Expect exactly 256 writes, then err_overlen=1 for one cycle with err_src=1.
  - Expect 4 beats discarded, then IDLE.
- Exact-length: 256-beat frame with last on beat 256 → 256 writes, no err_overlen.
- Reset mid-frame: rst_n=0 for 1 cycle during beat 3 of 6.
  - Expect fifo_wr_en=0 in that cycle and state=IDLE afterwards.
  - Expect rr_ptr=0: with reqs 0 and 2 pending, req 0 is granted first.
